// File: rtl/network_interface_if.sv
// Packet type and the grouped core/router signal bundle of the network interface.
// The slave modport is the network_interface view; master is the core+router side.
package network_interface_pkg;
   localparam int COORD_W         = 4;
   localparam int TIME_STAMP_SIZE = 8;
   localparam int PAYLOAD_W       = 16;

   typedef struct packed {
      logic [COORD_W-1:0]         x_dest;
      logic [COORD_W-1:0]         y_dest;
      logic [COORD_W-1:0]         x_source;
      logic [COORD_W-1:0]         y_source;
      logic [TIME_STAMP_SIZE-1:0] timestamp;
      logic [PAYLOAD_W-1:0]       payload;
   } packet_t;
endpackage

interface network_interface_if;
   import network_interface_pkg::*;

   packet_t                    i_core_data;
   logic                       i_core_data_val;
   logic                       o_core_en;
   packet_t                    o_data;
   logic                       o_data_val;
   logic                       i_en;
   packet_t                    i_data;
   logic                       i_data_val;
   logic                       o_en;
   packet_t                    o_core_data;
   logic                       o_core_data_val;
   logic                       i_core_en;
   logic [31:0]                o_sent_count;
   logic [31:0]                o_recv_count;
   logic                       o_misroute;
   logic [TIME_STAMP_SIZE-1:0] o_lat_max;

   modport slave (
      input  i_core_data, i_core_data_val, i_en, i_data, i_data_val, i_core_en,
      output o_core_en, o_data, o_data_val, o_en, o_core_data, o_core_data_val,
             o_sent_count, o_recv_count, o_misroute, o_lat_max
   );

   modport master (
      output i_core_data, i_core_data_val, i_en, i_data, i_data_val, i_core_en,
      input  o_core_en, o_data, o_data_val, o_en, o_core_data, o_core_data_val,
             o_sent_count, o_recv_count, o_misroute, o_lat_max
   );
endinterface

// File: rtl/network_interface.sv
// Router local-port endpoint: source-stamping inject FIFO plus a two-entry eject skid buffer.
// Define NI_LATENCY_STATS_EN to timestamp injected packets and track the worst eject latency.
module network_interface
   import network_interface_pkg::*;
#(
   parameter int                 DEPTH = 4,
   parameter logic [COORD_W-1:0] X_LOC = '0,
   parameter logic [COORD_W-1:0] Y_LOC = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   network_interface_if.slave   bus
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} eject_state_t;

   packet_t     fifo_mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic        fifo_empty, fifo_full, push, pop;
   packet_t     push_pkt;
   logic [31:0] sent_q, sent_d, recv_q, recv_d;

   eject_state_t state_q, state_d;
   packet_t      head_q, head_d, tail_q, tail_d;
   logic         accept, drain, misroute_q, misroute_d;

`ifdef NI_LATENCY_STATS_EN
   logic [TIME_STAMP_SIZE-1:0] cyc_q, lat, lat_max_q, lat_max_d;
`endif

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push       = bus.i_core_data_val && !fifo_full;
   assign pop        = !fifo_empty && bus.i_en;

   always_comb begin
      push_pkt          = bus.i_core_data;
      push_pkt.x_source = X_LOC;
      push_pkt.y_source = Y_LOC;
`ifdef NI_LATENCY_STATS_EN
      push_pkt.timestamp = cyc_q;
`endif
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      sent_d   = pop  ? sent_q + 32'd1 : sent_q;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q[AW-1:0]] <= push_pkt;
      end
   end

   assign bus.o_core_en  = !fifo_full;
   assign bus.o_data_val = !fifo_empty;
   assign bus.o_data     = fifo_mem_q[rd_ptr_q[AW-1:0]];

   assign accept = bus.i_data_val && (state_q != S_TWO);
   assign drain  = (state_q != S_EMPTY) && bus.i_core_en;

   // Head always holds the oldest packet; tail is only used in TWO.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         S_EMPTY: begin
            if (accept) begin
               state_d = S_ONE;
               head_d  = bus.i_data;
            end
         end
         S_ONE: begin
            if (accept && !drain) begin
               state_d = S_TWO;
               tail_d  = bus.i_data;
            end else if (drain && !accept) begin
               state_d = S_EMPTY;
            end else if (accept && drain) begin
               head_d  = bus.i_data;
            end
         end
         S_TWO: begin
            if (drain) begin
               state_d = S_ONE;
               head_d  = tail_q;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   always_comb begin
      recv_d     = accept ? recv_q + 32'd1 : recv_q;
      misroute_d = misroute_q ||
                   (accept && ((bus.i_data.x_dest != X_LOC) || (bus.i_data.y_dest != Y_LOC)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         sent_q     <= '0;
         recv_q     <= '0;
         state_q    <= S_EMPTY;
         misroute_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         sent_q     <= sent_d;
         recv_q     <= recv_d;
         state_q    <= state_d;
         misroute_q <= misroute_d;
      end
   end

   always_ff @(posedge clk) begin
      head_q <= head_d;
      tail_q <= tail_d;
   end

   assign bus.o_en            = (state_q != S_TWO);
   assign bus.o_core_data_val = (state_q != S_EMPTY);
   assign bus.o_core_data     = head_q;
   assign bus.o_sent_count    = sent_q;
   assign bus.o_recv_count    = recv_q;
   assign bus.o_misroute      = misroute_q;

`ifdef NI_LATENCY_STATS_EN
   // Modular subtraction gives the right latency across a counter wrap.
   assign lat       = cyc_q - bus.i_data.timestamp;
   assign lat_max_d = (accept && (lat > lat_max_q)) ? lat : lat_max_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_q     <= '0;
         lat_max_q <= '0;
      end else begin
         cyc_q     <= cyc_q + {{(TIME_STAMP_SIZE-1){1'b0}}, 1'b1};
         lat_max_q <= lat_max_d;
      end
   end

   assign bus.o_lat_max = lat_max_q;
`else
   assign bus.o_lat_max = '0;
`endif

endmodule

// File: tb/tb_network_interface.sv
// Directed bench for network_interface at node (1,2), DEPTH=4.
// Covers reset, inject fill/drain, eject backpressure, streaming, misroute and latency.
module tb_network_interface;
   import network_interface_pkg::*;

   logic       clk;
   logic       reset;
   int         n_vec;
   int         n_err;
   logic [7:0] tb_cyc;
   packet_t    lp;
   packet_t    pa, pb, pc;

   network_interface_if bus ();

   network_interface #(
      .DEPTH (4),
      .X_LOC (4'd1),
      .Y_LOC (4'd2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // tb_cyc mirrors the value the cycle counter holds going into the next edge.
   task automatic tick();
      @(posedge clk);
      if (reset) tb_cyc = 8'd0;
      else       tb_cyc = tb_cyc + 8'd1;
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic packet_t mk(input logic [3:0] xd, input logic [3:0] yd,
                                  input logic [15:0] pl);
      packet_t p;
      p.x_dest    = xd;
      p.y_dest    = yd;
      p.x_source  = 4'hF;
      p.y_source  = 4'hF;
      p.timestamp = 8'h33;
      p.payload   = pl;
      return p;
   endfunction

   initial begin
      n_vec  = 0;
      n_err  = 0;
      tb_cyc = 8'd0;
      reset  = 1'b1;
      bus.i_core_data     = mk(4'd1, 4'd2, 16'hDEAD);
      bus.i_core_data_val = 1'b1;
      bus.i_en            = 1'b0;
      bus.i_data          = mk(4'd1, 4'd2, 16'h0);
      bus.i_data_val      = 1'b0;
      bus.i_core_en       = 1'b0;

      // Reset held with a core write pending
      tick(); tick(); tick();
      check("rst_o_data_val", 64'(bus.o_data_val), 64'd0);
      check("rst_core_val", 64'(bus.o_core_data_val), 64'd0);
      check("rst_sent", 64'(bus.o_sent_count), 64'd0);
      check("rst_recv", 64'(bus.o_recv_count), 64'd0);
      check("rst_misroute", 64'(bus.o_misroute), 64'd0);
      check("rst_lat_max", 64'(bus.o_lat_max), 64'd0);
      reset = 1'b0;
      bus.i_core_data_val = 1'b0;
      tick();
      check("post_rst_core_en", 64'(bus.o_core_en), 64'd1);
      check("post_rst_en", 64'(bus.o_en), 64'd1);
      check("post_rst_o_data_val", 64'(bus.o_data_val), 64'd0);

      // Inject fill: five writes with the router stalled, only four fit
      for (int k = 0; k < 5; k++) begin
         bus.i_core_data     = mk(4'd3, 4'd0, 16'h0100 + 16'(k));
         bus.i_core_data_val = 1'b1;
         tick();
         if (k == 2) check("fill_core_en_3", 64'(bus.o_core_en), 64'd1);
         if (k == 3) check("fill_core_en_4", 64'(bus.o_core_en), 64'd0);
      end
      bus.i_core_data_val = 1'b0;
      check("fill_o_data_val", 64'(bus.o_data_val), 64'd1);
      check("fill_sent0", 64'(bus.o_sent_count), 64'd0);
      bus.i_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("inj_val", 64'(bus.o_data_val), 64'd1);
         check("inj_payload", 64'(bus.o_data.payload), 64'h0100 + 64'(k));
         check("inj_xsrc", 64'(bus.o_data.x_source), 64'd1);
         check("inj_ysrc", 64'(bus.o_data.y_source), 64'd2);
         check("inj_xdst", 64'(bus.o_data.x_dest), 64'd3);
`ifndef NI_LATENCY_STATS_EN
         check("inj_ts", 64'(bus.o_data.timestamp), 64'h33);
`endif
         tick();
      end
      check("inj_empty", 64'(bus.o_data_val), 64'd0);
      check("inj_sent4", 64'(bus.o_sent_count), 64'd4);
      check("inj_core_en", 64'(bus.o_core_en), 64'd1);
      bus.i_en = 1'b0;

      // Eject backpressure with the core stalled
      pa = mk(4'd1, 4'd2, 16'hA0A0);
      pb = mk(4'd1, 4'd2, 16'hB0B0);
      pc = mk(4'd1, 4'd2, 16'hC0C0);
      bus.i_data = pa; bus.i_data_val = 1'b1;
      tick();
      check("ej_en_one", 64'(bus.o_en), 64'd1);
      check("ej_val_one", 64'(bus.o_core_data_val), 64'd1);
      check("ej_head_a", 64'(bus.o_core_data), 64'(pa));
      bus.i_data = pb;
      tick();
      check("ej_en_two", 64'(bus.o_en), 64'd0);
      bus.i_data = pc;
      tick();
      check("ej_en_hold", 64'(bus.o_en), 64'd0);
      check("ej_recv2", 64'(bus.o_recv_count), 64'd2);
      check("ej_head_a_hold", 64'(bus.o_core_data), 64'(pa));
      bus.i_core_en = 1'b1;
      tick();
      check("ej_head_b", 64'(bus.o_core_data), 64'(pb));
      check("ej_en_reopen", 64'(bus.o_en), 64'd1);
      tick();
      check("ej_head_c", 64'(bus.o_core_data), 64'(pc));
      check("ej_recv3", 64'(bus.o_recv_count), 64'd3);
      bus.i_data_val = 1'b0;
      tick();
      check("ej_drained", 64'(bus.o_core_data_val), 64'd0);

      // Streaming: accept and drain together while in ONE
      bus.i_data = mk(4'd1, 4'd2, 16'h5000); bus.i_data_val = 1'b1;
      tick();
      for (int k = 0; k < 10; k++) begin
         bus.i_data = mk(4'd1, 4'd2, 16'h5001 + 16'(k));
         check("str_head", 64'(bus.o_core_data.payload), 64'h5000 + 64'(k));
         check("str_en", 64'(bus.o_en), 64'd1);
         tick();
      end
      bus.i_data_val = 1'b0;
      check("str_last", 64'(bus.o_core_data.payload), 64'h500A);
      tick();
      check("str_recv", 64'(bus.o_recv_count), 64'd14);
      check("str_empty", 64'(bus.o_core_data_val), 64'd0);
      check("str_misroute0", 64'(bus.o_misroute), 64'd0);

      // Misroute: destination (2,2) arrives at node (1,2)
      bus.i_data = mk(4'd2, 4'd2, 16'hBAD0); bus.i_data_val = 1'b1;
      tick();
      check("mis_set", 64'(bus.o_misroute), 64'd1);
      check("mis_delivered", 64'(bus.o_core_data.payload), 64'hBAD0);
      bus.i_data = mk(4'd1, 4'd2, 16'h600D);
      tick();
      bus.i_data_val = 1'b0;
      tick();
      check("mis_sticky", 64'(bus.o_misroute), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mis_cleared", 64'(bus.o_misroute), 64'd0);
      check("rst2_recv", 64'(bus.o_recv_count), 64'd0);

`ifdef NI_LATENCY_STATS_EN
      // Loopback with a 7-cycle router delay: accept lands 8 edges after the write
      bus.i_en = 1'b1;
      bus.i_core_data = mk(4'd1, 4'd2, 16'h1A7); bus.i_core_data_val = 1'b1;
      tick();
      bus.i_core_data_val = 1'b0;
      lp = bus.o_data;
      tick();
      for (int k = 0; k < 6; k++) tick();
      bus.i_data = lp; bus.i_data_val = 1'b1;
      tick();
      bus.i_data_val = 1'b0;
      check("lat_max_8", 64'(bus.o_lat_max), 64'd8);
      // Near counter wrap: write at count 250, accept 12 edges later
      while (tb_cyc != 8'd250) tick();
      bus.i_core_data = mk(4'd1, 4'd2, 16'h2A7); bus.i_core_data_val = 1'b1;
      tick();
      bus.i_core_data_val = 1'b0;
      lp = bus.o_data;
      tick();
      for (int k = 0; k < 10; k++) tick();
      bus.i_data = lp; bus.i_data_val = 1'b1;
      tick();
      bus.i_data_val = 1'b0;
      check("lat_max_wrap", 64'(bus.o_lat_max), 64'd12);
`else
      bus.i_data = mk(4'd1, 4'd2, 16'h0001); bus.i_data_val = 1'b1;
      tick();
      bus.i_data_val = 1'b0;
      check("lat_max_tied", 64'(bus.o_lat_max), 64'd0);
      check("ts_passthru", 64'(bus.o_core_data.timestamp), 64'h33);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
